// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I decode types: opcodes, ALU ops, immediate formats, decode bundle
package rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    alu_op_e    aluOp;
    logic       aluSrcImm;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic       illegal;
  } decode_t;

  // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
  function automatic alu_op_e aluOpBase(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e aluOpMul(input logic [2:0] funct3);
    case (funct3)
      3'd0:    return ALU_MUL;
      3'd1:    return ALU_MULH;
      3'd2:    return ALU_MULHSU;
      3'd3:    return ALU_MULHU;
      3'd4:    return ALU_DIV;
      3'd5:    return ALU_DIVU;
      3'd6:    return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational I/S/B/U/J immediate extraction, sign-extended to XLEN
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_type_e       immType,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;
  logic unusedOpcode;

  assign unusedOpcode = ^inst[6:0];

  always_comb begin
    imm32 = '0;
    case (immType)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // signed cast sign-extends when XLEN is 64
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I decode stage with valid/ready, flush, illegal counter
// Optional M-extension decode under RV_DECODE_MEXT_EN.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_alu_op,
  output logic             out_alu_src_imm,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_lui,
  output logic             out_auipc,
  output logic [2:0]       out_funct3,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int SHAMT_W = $clog2(XLEN);

  decode_t          dec;
  decode_t          outBundle;
  imm_type_e        immType;
  logic             immZero;
  logic             shiftImm;
  logic             shiftHiOk;
  logic             illegal;
  logic [XLEN-1:0]  immRaw;
  logic [XLEN-1:0]  immSel;
  logic [XLEN-1:0]  outImm;
  logic [PC_W-1:0]  outPc;
  logic             outValid;
  logic [CNT_W-1:0] illegalCount;
  logic             accept;

  wire [6:0] opcode = in_inst[6:0];
  wire [2:0] funct3 = in_inst[14:12];
  wire [6:0] funct7 = in_inst[31:25];

  rv_imm_gen #(.XLEN(XLEN)) uImmGen (
    .inst    (in_inst),
    .immType (immType),
    .imm     (immRaw)
  );

  // bits above shamt must be zero except bit 30, which only SRAI may set
  assign shiftHiOk = !in_inst[31] && (in_inst[29:20+SHAMT_W] == '0)
                     && (!in_inst[30] || funct3 == 3'd5);

  always_comb begin
    dec        = '0;
    immType    = IMM_I;
    immZero    = 1'b0;
    shiftImm   = 1'b0;
    illegal    = 1'b0;
    dec.rd     = in_inst[11:7];
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.funct3 = funct3;
    dec.aluOp  = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.regWrite = 1'b1;
        immZero      = 1'b1;
        if (funct7 == 7'h00)
          dec.aluOp = aluOpBase(funct3, 1'b0);
        else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))
          dec.aluOp = aluOpBase(funct3, 1'b1);
`ifdef RV_DECODE_MEXT_EN
        else if (funct7 == 7'h01)
          dec.aluOp = aluOpMul(funct3);
`endif
        else
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        if (funct3 == 3'd1 || funct3 == 3'd5) begin
          shiftImm  = 1'b1;
          illegal   = !shiftHiOk;
          dec.aluOp = aluOpBase(funct3, funct3 == 3'd5 && in_inst[30]);
        end else begin
          dec.aluOp = aluOpBase(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        dec.regWrite  = 1'b1;
        dec.memRead   = 1'b1;
        dec.aluSrcImm = 1'b1;
        illegal       = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
      end
      OPC_STORE: begin
        dec.memWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        immType       = IMM_S;
        illegal       = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.aluOp  = ALU_SUB;
        immType    = IMM_B;
        illegal    = (funct3 == 3'd2 || funct3 == 3'd3);
      end
      OPC_JALR: begin
        dec.jalr      = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        illegal       = (funct3 != 3'd0);
      end
      OPC_JAL: begin
        dec.jal       = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        immType       = IMM_J;
      end
      OPC_LUI: begin
        dec.lui       = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        immType       = IMM_U;
      end
      OPC_AUIPC: begin
        dec.auipc     = 1'b1;
        dec.regWrite  = 1'b1;
        dec.aluSrcImm = 1'b1;
        immType       = IMM_U;
      end
      OPC_SYSTEM, OPC_MISC_MEM: immZero = 1'b1;
      default: illegal = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11)
      illegal = 1'b1;
    if (dec.rd == 5'd0)
      dec.regWrite = 1'b0;
    if (illegal) begin
      dec.aluOp     = ALU_ADD;
      dec.aluSrcImm = 1'b0;
      dec.regWrite  = 1'b0;
      dec.memRead   = 1'b0;
      dec.memWrite  = 1'b0;
      dec.branch    = 1'b0;
      dec.jal       = 1'b0;
      dec.jalr      = 1'b0;
      dec.lui       = 1'b0;
      dec.auipc     = 1'b0;
    end
    dec.illegal = illegal;
  end

  always_comb begin
    immSel = immRaw;
    if (immZero)
      immSel = '0;
    else if (shiftImm)
      immSel = XLEN'(in_inst[20 +: SHAMT_W]);
  end

  assign in_ready = !outValid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid     <= 1'b0;
      outBundle    <= '0;
      outImm       <= '0;
      outPc        <= '0;
      illegalCount <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (accept) begin
      outValid  <= 1'b1;
      outBundle <= dec;
      outImm    <= immSel;
      outPc     <= in_pc;
      if (dec.illegal && illegalCount != '1)
        illegalCount <= illegalCount + CNT_W'(1);
    end else if (out_ready) begin
      outValid <= 1'b0;
    end
  end

  assign out_valid       = outValid;
  assign out_pc          = outPc;
  assign out_imm         = outImm;
  assign out_rd          = outBundle.rd;
  assign out_rs1         = outBundle.rs1;
  assign out_rs2         = outBundle.rs2;
  assign out_funct3      = outBundle.funct3;
  assign out_alu_op      = outBundle.aluOp;
  assign out_alu_src_imm = outBundle.aluSrcImm;
  assign out_reg_write   = outBundle.regWrite;
  assign out_mem_read    = outBundle.memRead;
  assign out_mem_write   = outBundle.memWrite;
  assign out_branch      = outBundle.branch;
  assign out_jal         = outBundle.jal;
  assign out_jalr        = outBundle.jalr;
  assign out_lui         = outBundle.lui;
  assign out_auipc       = outBundle.auipc;
  assign out_illegal     = outBundle.illegal;
  assign illegal_count   = illegalCount;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - directed self-checking bench for rv_decode_stage
module tb_rv_decode_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [4:0]  out_alu_op;
  logic        out_alu_src_imm, out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jal, out_jalr, out_lui, out_auipc;
  logic [2:0]  out_funct3;
  logic        out_illegal;
  logic [15:0] illegal_count;

  int testCount = 0;
  int failCount = 0;
  int expCnt    = 0;

  always #5 clk = ~clk;

  rv_decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_alu_src_imm(out_alu_src_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jal(out_jal),
    .out_jalr(out_jalr), .out_lui(out_lui), .out_auipc(out_auipc),
    .out_funct3(out_funct3), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_count", illegal_count, 0);
    check("rst_imm", out_imm, 0);
    check("rst_regwr", out_reg_write, 0);
    check("rst_ready", in_ready, 1);
    reset = 1'b0;

    send(32'hFFF00093, 32'h100);
    check("addi_valid", out_valid, 1);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_alu", out_alu_op, ALU_ADD);
    check("addi_srcimm", out_alu_src_imm, 1);
    check("addi_regwr", out_reg_write, 1);
    check("addi_rd", out_rd, 1);
    check("addi_pc", out_pc, 32'h100);

    send(32'hFE000EE3, 32'h104);
    check("beq_branch", out_branch, 1);
    check("beq_alu", out_alu_op, ALU_SUB);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_regwr", out_reg_write, 0);
    check("beq_illegal", out_illegal, 0);

    // hold BEQ under backpressure while ADD x0 waits at the input
    out_ready = 1'b0;
    in_inst   = 32'h00208033;
    in_pc     = 32'h108;
    #1;
    check("bp_inready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_pc", out_pc, 32'h104);
      check("bp_imm", out_imm, 32'hFFFFFFFC);
      check("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("addx0_valid", out_valid, 1);
    check("addx0_pc", out_pc, 32'h108);
    check("addx0_regwr", out_reg_write, 0);
    check("addx0_illegal", out_illegal, 0);
    check("addx0_alu", out_alu_op, ALU_ADD);

    send(32'h022081B3, 32'h10C);
    check("mul_valid", out_valid, 1);
    check("mul_pc", out_pc, 32'h10C);
`ifdef RV_DECODE_MEXT_EN
    check("mul_alu", out_alu_op, ALU_MUL);
    check("mul_regwr", out_reg_write, 1);
    check("mul_illegal", out_illegal, 0);
`else
    expCnt++;
    check("mul_illegal", out_illegal, 1);
    check("mul_regwr", out_reg_write, 0);
`endif
    check("mul_count", illegal_count, expCnt);

    // flush with a held entry and an illegal input in the same cycle
    out_ready = 1'b0;
    flush     = 1'b1;
    send(32'h00000000, 32'h110);
    check("flush_valid", out_valid, 0);
    check("flush_count", illegal_count, expCnt);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("flush_idle", out_valid, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_count", illegal_count, 0);

    send(32'h00000000, 32'h200);
    check("zero_illegal", out_illegal, 1);
    check("zero_valid", out_valid, 1);
    check("zero_regwr", out_reg_write, 0);
    check("zero_memrd", out_mem_read, 0);
    check("zero_count", illegal_count, 1);
    send(32'h0000707F, 32'h204);
    check("st7_illegal", out_illegal, 1);
    check("st7_memwr", out_mem_write, 0);
    check("st7_srcimm", out_alu_src_imm, 0);
    check("st7_count", illegal_count, 2);

    send(32'h00402183, 32'h208);
    check("lw_memrd", out_mem_read, 1);
    check("lw_imm", out_imm, 4);
    check("lw_regwr", out_reg_write, 1);
    check("lw_funct3", out_funct3, 2);
    send(32'hFE20AC23, 32'h20C);
    check("sw_memwr", out_mem_write, 1);
    check("sw_imm", out_imm, 32'hFFFFFFF8);
    check("sw_regwr", out_reg_write, 0);
    check("sw_rs1", out_rs1, 1);
    check("sw_rs2", out_rs2, 2);
    send(32'h40335293, 32'h210);
    check("srai_alu", out_alu_op, ALU_SRA);
    check("srai_imm", out_imm, 3);
    check("srai_illegal", out_illegal, 0);
    send(32'h008000EF, 32'h214);
    check("jal_jal", out_jal, 1);
    check("jal_imm", out_imm, 8);
    check("jal_regwr", out_reg_write, 1);
    send(32'h123453B7, 32'h218);
    check("lui_lui", out_lui, 1);
    check("lui_imm", out_imm, 32'h12345000);
    check("lui_rd", out_rd, 7);
    send(32'h00000073, 32'h21C);
    check("ecall_illegal", out_illegal, 0);
    check("ecall_regwr", out_reg_write, 0);
    check("ecall_valid", out_valid, 1);
    check("ecall_count", illegal_count, 2);

    in_inst = 32'h00000000;
    repeat (65539) tick();
    check("sat_count", illegal_count, 16'hFFFF);
    check("sat_illegal", out_illegal, 1);
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
